writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of loads in flight (2..8).
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have issue_valid, input, 1 bit: a load issues this cycle.
REQ-005 SHALL have issue_rd, input, 5 bits: destination register of the issuing load.
REQ-006 SHALL have issue_ready, output, 1 bit: a load may issue (outstanding count < MAX_OUTST).
REQ-007 SHALL have alu_valid / alu_rd / alu_wd, inputs, 1/5/32 bits: ALU result; never stalled.
REQ-008 SHALL have ld_valid / ld_rd / ld_wd, inputs, 1/5/32 bits: load return data.
REQ-009 SHALL have ld_ready, output, 1 bit: a load return is accepted this cycle.
REQ-010 SHALL have ra1 / ra2, inputs, 5 bits each: decode-stage source registers.
REQ-011 SHALL have stall, output, 1 bit: a source register has a pending load.
REQ-012 SHALL have werf / wa / wd, outputs, 1/5/32 bits: register-file write port.
REQ-013 SHALL have waw_err, output, 1 bit: sticky ALU-write-to-busy-register error.

Function
REQ-014 SHALL accept a load return when ld_valid && ld_ready; ld_ready = !alu_valid (ALU has fixed priority).
REQ-015 SHALL register the selected write (ALU else accepted load) onto werf/wa/wd with exactly 1-cycle latency.
REQ-016 SHALL drive werf=0 the next cycle when neither source writes, or when the selected rd is 0 (an x0 write is discarded but still retires a load).
REQ-017 SHALL keep a 32-bit busy vector: set bit issue_rd on an accepted issue (issue_valid && issue_ready, rd != 0); clear bit ld_rd on an accepted load return.
REQ-018 SHALL, on simultaneous set and clear of the same bit, leave the bit set.
REQ-019 SHALL keep an outstanding counter: +1 per accepted issue (x0 included), -1 per accepted return; simultaneous +1/-1 leaves it unchanged.
REQ-020 SHALL ignore issue_valid when issue_ready=0; a return with count=0 SHALL not underflow (count stays 0).
REQ-021 SHALL drive stall combinationally = (ra1!=0 && busy[ra1]) || (ra2!=0 && busy[ra2]), with no bypass from a same-cycle clear.
REQ-022 SHALL set waw_err when alu_valid && alu_rd!=0 && busy[alu_rd]; it holds until reset, and the ALU write still proceeds.
REQ-023 SHALL hold the load source pending (no data loss) for as many cycles as alu_valid stays high.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force werf=0, wa=0, wd=0, busy=0, count=0, waw_err=0.
REQ-025 SHALL drop an in-flight load tracked before reset; issue_ready=1 from the first cycle after deassertion.

Structure
REQ-026 SHALL take XLEN=32, REG_ADDR_W=5 and the type reg_addr_t from the shared package regfile_pkg.
REQ-027 SHALL place the busy vector, the counter and the stall logic in the sub-module wb_scoreboard; arbitration and output registers stay at the top level.

Verification
REQ-028 SHALL cover: alu_valid=1, rd=5, wd=0xDEADBEEF -> next cycle werf=1, wa=5, wd=0xDEADBEEF.
REQ-029 SHALL cover: ld_valid=1 and alu_valid=1 for 3 cycles -> ld_ready=0 for 3 cycles; the load writes on cycle 4+1, with no data loss.
REQ-030 SHALL cover: issue rd=7, then ra1=7 -> stall=1 until the load return for rd=7 is accepted; stall=0 the following cycle.
REQ-031 SHALL cover: 4 issues with no returns (MAX_OUTST=4) -> issue_ready=0; one return -> issue_ready=1.
REQ-032 SHALL cover: ALU write rd=0 -> werf=0; ALU write to busy rd=3 -> waw_err=1 (sticky) and the write occurs.
REQ-033 SHALL cover: rst_n pulsed low with 2 loads pending -> busy=0, count=0, werf=0 immediately; issue_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file widths and address type used by the writeback path.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Load scoreboard: per-register busy bits, outstanding-load counter and the
// decode-stage stall check.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      ret_valid,
    input  reg_addr_t ret_rd,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    input  reg_addr_t chk_rd,
    output logic      issue_ready,
    output logic      stall,
    output logic      chk_busy
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                issue_acc;

    assign issue_ready = (count_q < CNT_W'(MAX_OUTST));
    assign issue_acc   = issue_valid && issue_ready;

    // x0 is never tracked, so its mask bits are tied off.
    assign set_mask[0] = 1'b0;
    assign clr_mask[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_mask
        assign set_mask[gi] = issue_acc && (issue_rd == REG_ADDR_W'(gi));
        assign clr_mask[gi] = ret_valid && (ret_rd == REG_ADDR_W'(gi));
    end

    // Applying the set after the clear lets a same-cycle reissue win.
    assign busy_d = (busy_q & ~clr_mask) | set_mask;

    always_comb begin
        count_d = count_q;
        if (issue_acc && !ret_valid) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue_acc && ret_valid && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign stall    = ((ra1 != '0) && busy_q[ra1]) || ((ra2 != '0) && busy_q[ra2]);
    assign chk_busy = busy_q[chk_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: ALU results take fixed priority over load returns, the
// winner is registered onto the register-file write port one cycle later.
module writeback_unit
    import regfile_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_wd,
    output logic            ld_ready,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic            stall,
    output logic            werf,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd,
    output logic            waw_err
);

    logic      ld_acc;
    logic      alu_busy;
    logic      werf_q, werf_d;
    reg_addr_t wa_q, wa_d;
    reg_data_t wd_q, wd_d;
    logic      waw_q, waw_d;

    // A blocked load simply keeps ld_valid asserted; nothing is buffered here.
    assign ld_ready = !alu_valid;
    assign ld_acc   = ld_valid && ld_ready;

    wb_scoreboard #(
        .MAX_OUTST (MAX_OUTST)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .ret_valid   (ld_acc),
        .ret_rd      (ld_rd),
        .ra1         (ra1),
        .ra2         (ra2),
        .chk_rd      (alu_rd),
        .issue_ready (issue_ready),
        .stall       (stall),
        .chk_busy    (alu_busy)
    );

    always_comb begin
        werf_d = 1'b0;
        wa_d   = '0;
        wd_d   = '0;
        if (alu_valid) begin
            werf_d = (alu_rd != '0);
            wa_d   = alu_rd;
            wd_d   = alu_wd;
        end else if (ld_acc) begin
            werf_d = (ld_rd != '0);
            wa_d   = ld_rd;
            wd_d   = ld_wd;
        end
    end

    assign waw_d = waw_q || (alu_valid && (alu_rd != '0) && alu_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            werf_q <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            waw_q  <= 1'b0;
        end else begin
            werf_q <= werf_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            waw_q  <= waw_d;
        end
    end

    assign werf    = werf_q;
    assign wa      = wa_q;
    assign wd      = wd_q;
    assign waw_err = waw_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: hand-derived vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_writeback_unit;

    localparam int MAX_OUTST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_wd;
    logic        ld_ready;
    logic [4:0]  ra1, ra2;
    logic        stall;
    logic        werf;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        waw_err;

    writeback_unit #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk (clk), .rst_n (rst_n),
        .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_ready (issue_ready),
        .alu_valid (alu_valid), .alu_rd (alu_rd), .alu_wd (alu_wd),
        .ld_valid (ld_valid), .ld_rd (ld_rd), .ld_wd (ld_wd), .ld_ready (ld_ready),
        .ra1 (ra1), .ra2 (ra2), .stall (stall),
        .werf (werf), .wa (wa), .wd (wd), .waw_err (waw_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        iv;  bit [4:0] ird;
        bit        av;  bit [4:0] ard; bit [31:0] awd;
        bit        lv;  bit [4:0] lrd; bit [31:0] lwd;
        bit [4:0]  r1;  bit [4:0] r2;
    } stim_t;

    typedef struct {
        stim_t     s;
        bit        e_ir; bit e_ldr; bit e_stall;
        bit        e_werf; bit [4:0] e_wa; bit [31:0] e_wd; bit e_waw;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: which registers await a load, how many loads are out.
    bit m_busy [32];
    int m_cnt;
    bit m_waw;

    // Last observed DUT values, for table checks layered on the model.
    bit        o_ir, o_ldr, o_stall, o_werf, o_waw;
    bit [4:0]  o_wa;
    bit [31:0] o_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_cnt = 0;
        m_waw = 1'b0;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        issue_valid = s.iv; issue_rd = s.ird;
        alu_valid = s.av; alu_rd = s.ard; alu_wd = s.awd;
        ld_valid = s.lv; ld_rd = s.lrd; ld_wd = s.lwd;
        ra1 = s.r1; ra2 = s.r2;
    endtask

    // One clock of traffic: drive at negedge, check combinational outputs,
    // advance the model, then check registered outputs just after posedge.
    task automatic run_cycle(input stim_t s, input bit verbose);
        bit        e_ir, e_ldr, e_st, iss, ret, e_werf;
        bit [4:0]  e_wa;
        bit [31:0] e_wd;
        @(negedge clk);
        drive(s);
        #1;
        e_ir  = (m_cnt < MAX_OUTST);
        e_ldr = !s.av;
        e_st  = (s.r1 != 0 && m_busy[s.r1]) || (s.r2 != 0 && m_busy[s.r2]);
        chk("issue_ready", issue_ready, e_ir);
        chk("ld_ready", ld_ready, e_ldr);
        chk("stall", stall, e_st);
        o_ir = issue_ready; o_ldr = ld_ready; o_stall = stall;

        iss = s.iv && e_ir;
        ret = s.lv && e_ldr;
        e_werf = 0; e_wa = 0; e_wd = 0;
        if (s.av) begin
            e_werf = (s.ard != 0); e_wa = s.ard; e_wd = s.awd;
            if (s.ard != 0 && m_busy[s.ard]) m_waw = 1'b1;
        end else if (ret) begin
            e_werf = (s.lrd != 0); e_wa = s.lrd; e_wd = s.lwd;
        end
        if (ret) m_busy[s.lrd] = 1'b0;
        if (iss && s.ird != 0) m_busy[s.ird] = 1'b1;
        m_cnt = m_cnt + int'(iss) - int'(ret);
        if (m_cnt < 0) m_cnt = 0;

        @(posedge clk);
        #1;
        chk("werf", werf, e_werf);
        if (e_werf) begin
            chk("wa", wa, e_wa);
            chk("wd", wd, e_wd);
        end
        chk("waw_err", waw_err, m_waw);
        o_werf = werf; o_wa = wa; o_wd = wd; o_waw = waw_err;
        if (verbose)
            $display("txn iv=%0d ird=%0d av=%0d ard=%0d lv=%0d lrd=%0d | ir=%0d ldr=%0d st=%0d -> werf=%0d wa=%0d wd=%08h waw=%0d",
                     s.iv, s.ird, s.av, s.ard, s.lv, s.lrd, o_ir, o_ldr, o_stall, werf, wa, wd, waw_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(idle());
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t  tbl [10];
    stim_t s;

    initial begin
        rst_n = 1'b0;
        drive(idle());
        model_reset();
        #12;
        chk("reset_werf", werf, 0);
        chk("reset_wa", wa, 0);
        chk("reset_wd", wd, 0);
        chk("reset_waw", waw_err, 0);
        chk("reset_issue_ready", issue_ready, 1);
        do_reset();

        // Hand-derived sequence starting from reset; each row is one cycle.
        for (int i = 0; i < 10; i++) begin
            tbl[i].s = idle();
            tbl[i].e_ir = 1; tbl[i].e_ldr = 1; tbl[i].e_stall = 0;
            tbl[i].e_werf = 0; tbl[i].e_wa = 0; tbl[i].e_wd = 0; tbl[i].e_waw = 0;
        end
        tbl[0].s.av = 1; tbl[0].s.ard = 5; tbl[0].s.awd = 32'hDEADBEEF;
        tbl[0].e_ldr = 0; tbl[0].e_werf = 1; tbl[0].e_wa = 5; tbl[0].e_wd = 32'hDEADBEEF;
        tbl[1].s.iv = 1; tbl[1].s.ird = 7; tbl[1].s.r1 = 7;
        tbl[2].s.r1 = 7; tbl[2].e_stall = 1;
        tbl[3].s.lv = 1; tbl[3].s.lrd = 7; tbl[3].s.lwd = 32'h77; tbl[3].s.r1 = 7;
        tbl[3].e_stall = 1; tbl[3].e_werf = 1; tbl[3].e_wa = 7; tbl[3].e_wd = 32'h77;
        tbl[4].s.r1 = 7;
        tbl[5].s.av = 1; tbl[5].s.ard = 0; tbl[5].s.awd = 32'h1234; tbl[5].e_ldr = 0;
        tbl[6].s.iv = 1; tbl[6].s.ird = 3;
        tbl[7].s.av = 1; tbl[7].s.ard = 3; tbl[7].s.awd = 32'hCAFE; tbl[7].e_ldr = 0;
        tbl[7].e_werf = 1; tbl[7].e_wa = 3; tbl[7].e_wd = 32'hCAFE; tbl[7].e_waw = 1;
        tbl[8].s.lv = 1; tbl[8].s.lrd = 3; tbl[8].s.lwd = 32'h33; tbl[8].s.r2 = 3;
        tbl[8].e_stall = 1; tbl[8].e_werf = 1; tbl[8].e_wa = 3; tbl[8].e_wd = 32'h33; tbl[8].e_waw = 1;
        tbl[9].e_waw = 1;

        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].s, 1'b1);
            chk("tbl_issue_ready", o_ir, tbl[i].e_ir);
            chk("tbl_ld_ready", o_ldr, tbl[i].e_ldr);
            chk("tbl_stall", o_stall, tbl[i].e_stall);
            chk("tbl_werf", o_werf, tbl[i].e_werf);
            if (tbl[i].e_werf) begin
                chk("tbl_wa", o_wa, tbl[i].e_wa);
                chk("tbl_wd", o_wd, tbl[i].e_wd);
            end
            chk("tbl_waw", o_waw, tbl[i].e_waw);
        end

        // Load held off by three ALU cycles, then written on the fourth.
        do_reset();
        s = idle(); s.iv = 1; s.ird = 9;
        run_cycle(s, 1'b1);
        for (int c = 0; c < 3; c++) begin
            s = idle(); s.lv = 1; s.lrd = 9; s.lwd = 32'h9999_0009;
            s.av = 1; s.ard = 5'(c + 1); s.awd = 32'h100 + c;
            run_cycle(s, 1'b1);
            chk("prio_ld_ready", o_ldr, 0);
            chk("prio_wa", o_wa, 5'(c + 1));
        end
        s = idle(); s.lv = 1; s.lrd = 9; s.lwd = 32'h9999_0009;
        run_cycle(s, 1'b1);
        chk("held_ld_ready", o_ldr, 1);
        chk("held_werf", o_werf, 1);
        chk("held_wa", o_wa, 9);
        chk("held_wd", o_wd, 32'h9999_0009);

        // Fill to MAX_OUTST, extra issue is ignored, one return reopens.
        for (int k = 0; k < MAX_OUTST + 1; k++) begin
            s = idle(); s.iv = 1; s.ird = 5'(12 + k);
            run_cycle(s, 1'b1);
            chk("fill_issue_ready", o_ir, (k < MAX_OUTST) ? 1 : 0);
        end
        s = idle(); s.r1 = 5'(12 + MAX_OUTST);
        run_cycle(s, 1'b1);
        chk("ignored_issue_not_busy", o_stall, 0);
        chk("full_issue_ready", o_ir, 0);
        s = idle(); s.lv = 1; s.lrd = 12; s.lwd = 32'h12;
        run_cycle(s, 1'b1);
        s = idle();
        run_cycle(s, 1'b1);
        chk("reopen_issue_ready", o_ir, 1);

        // Asynchronous reset with two loads pending and a write on the port.
        do_reset();
        s = idle(); s.iv = 1; s.ird = 10; run_cycle(s, 1'b1);
        s = idle(); s.iv = 1; s.ird = 11; run_cycle(s, 1'b1);
        s = idle(); s.av = 1; s.ard = 10; s.awd = 32'hA5A5_0010; s.r1 = 10;
        run_cycle(s, 1'b1);
        chk("pre_rst_werf", werf, 1);
        chk("pre_rst_stall", stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_werf", werf, 0);
        chk("async_rst_wa", wa, 0);
        chk("async_rst_wd", wd, 0);
        chk("async_rst_stall", stall, 0);
        chk("async_rst_waw", waw_err, 0);
        chk("async_rst_issue_ready", issue_ready, 1);
        model_reset();
        @(negedge clk);
        drive(idle());
        rst_n = 1'b1;
        s = idle(); s.r1 = 10; s.r2 = 11;
        run_cycle(s, 1'b1);
        chk("post_rst_stall", o_stall, 0);
        chk("post_rst_issue_ready", o_ir, 1);

        // Randomized traffic on a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            s.iv  = ($urandom_range(0, 99) < 40);
            s.ird = 5'($urandom_range(0, 7));
            s.av  = ($urandom_range(0, 99) < 35);
            s.ard = 5'($urandom_range(0, 7));
            s.awd = $urandom;
            s.lv  = ($urandom_range(0, 99) < 45);
            s.lrd = 5'($urandom_range(0, 7));
            s.lwd = $urandom;
            s.r1  = 5'($urandom_range(0, 7));
            s.r2  = 5'($urandom_range(0, 7));
            run_cycle(s, 1'b0);
            if (n == 199) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
